// File: rtl/reg4x16_mem.sv
// -----------------------------------------------------------------------------
// reg4x16_mem
//   Storage stage placed directly after the sel/wr access FSM. It is a DEPTH x
//   DATA_W register memory sequenced through IDLE -> WRITE/READ -> IDLE.
//   A request is accepted when ready=1 and sel=1. The request completes on the
//   next edge. Completion is reported by a one-cycle wdone (write) or a
//   one-cycle rvalid with rdata (read). The default build is 4 words x 16 bits.
//
// Optional feature macro: REG4_MEM_PARITY_EN
//   When this macro is defined, each word carries a parity bit (^data) and the
//   par_inj port is present. A set par_inj inverts the stored parity bit of
//   that write. A read whose data parity disagrees with the stored bit raises
//   err. When the macro is undefined, there is no parity storage, no par_inj
//   port, and err reports only out-of-range addresses.
//
// Ports
//   clk      in   1       clock, all logic on posedge
//   reset    in   1       synchronous, active-high
//   sel      in   1       request strobe
//   wr       in   1       1 = write, 0 = read (sampled at acceptance)
//   addr     in   ADDR_W  word address (sampled at acceptance)
//   wdata    in   DATA_W  write data (sampled at acceptance)
//   par_inj  in   1       [REG4_MEM_PARITY_EN] invert stored parity of this write
//   ready    out  1       can accept a request this cycle (state == IDLE)
//   wdone    out  1       one-cycle pulse: write completed
//   rvalid   out  1       one-cycle pulse: rdata holds the completed read
//   rdata    out  DATA_W  last read data, held until the next read completes
//   err      out  1       one-cycle pulse with wdone/rvalid: operation error
// -----------------------------------------------------------------------------
module reg4x16_mem #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef REG4_MEM_PARITY_EN
  input  logic              par_inj,
`endif
  output logic              ready,
  output logic              wdone,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;

  state_e              state_q;

  // Request captured at acceptance
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wr_q;

  // Storage
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Registered outputs
  logic                wdone_q;
  logic                rvalid_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  // Derived from the captured request
  logic                in_range_d;
  logic                mem_we_d;
  logic [DATA_W-1:0]   rd_word_d;
  logic                rd_err_d;

`ifdef REG4_MEM_PARITY_EN
  logic [DEPTH-1:0]    par_q;
  logic                par_inj_q;
  logic                par_bit_d;
`endif

  // ---------------------------------------------------------------------------
  // Address decode and read-side data. Out-of-range addresses never index the
  // array. Reads of those addresses return zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_range_d = (32'(addr_q) < DEPTH);
    mem_we_d   = (state_q == WRITE) && wr_q && in_range_d;
    rd_word_d  = '0;
    rd_err_d   = !in_range_d;
    if (in_range_d) begin
      rd_word_d = mem_q[addr_q];
    end
`ifdef REG4_MEM_PARITY_EN
    par_bit_d = (^wdata_q) ^ par_inj_q;
    if (in_range_d && ((^mem_q[addr_q]) != par_q[addr_q])) begin
      rd_err_d = 1'b1;
    end
`endif
  end

  assign ready = (state_q == IDLE);

  // ---------------------------------------------------------------------------
  // Sequencer, storage and registered status. Reset in any state abandons the
  // in-flight operation. Completion pulses are suppressed on that edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      mem_q    <= '{default: '0};
      wdone_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
`ifdef REG4_MEM_PARITY_EN
      par_q     <= '0;
      par_inj_q <= 1'b0;
`endif
    end else begin
      wdone_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (sel) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            wr_q    <= wr;
`ifdef REG4_MEM_PARITY_EN
            par_inj_q <= par_inj;
`endif
            state_q <= wr ? WRITE : READ;
          end
        end

        WRITE: begin
          if (mem_we_d) begin
            mem_q[addr_q] <= wdata_q;
`ifdef REG4_MEM_PARITY_EN
            par_q[addr_q] <= par_bit_d;
`endif
          end
          wdone_q <= 1'b1;
          err_q   <= !in_range_d;
          state_q <= IDLE;
        end

        READ: begin
          rdata_q  <= rd_word_d;
          rvalid_q <= 1'b1;
          err_q    <= rd_err_d;
          state_q  <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign wdone  = wdone_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_reg4x16_mem.sv
// -----------------------------------------------------------------------------
// tb_reg4x16_mem
//   Directed and random checks of reg4x16_mem, instantiated with DEPTH=3 so
//   that address 3 is out of range. The reference model is a plain array of
//   words plus one "parity corrupted" flag per word.
// -----------------------------------------------------------------------------
module tb_reg4x16_mem;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEP   = 3;
  localparam int unsigned AW    = 2;

  logic          clk;
  logic          reset;
  logic          sel;
  logic          wr;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
`ifdef REG4_MEM_PARITY_EN
  logic          par_inj;
`endif
  logic          ready;
  logic          wdone;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          err;

  reg4x16_mem #(
    .DATA_W(DW),
    .DEPTH (DEP),
    .ADDR_W(AW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
`ifdef REG4_MEM_PARITY_EN
    .par_inj(par_inj),
`endif
    .ready  (ready),
    .wdone  (wdone),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  logic [DW-1:0] m_mem [4];
  bit            m_bad [4];
  logic [DW-1:0] m_rdata;

  int unsigned n_total;
  int unsigned n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mem[i] = '0;
      m_bad[i] = 1'b0;
    end
    m_rdata = '0;
  endtask

  task automatic set_inj(input bit v);
`ifdef REG4_MEM_PARITY_EN
    par_inj = v;
`else
    if (v) begin end
`endif
  endtask

  // Called at posedge+1. The wait for ready is bounded.
  task automatic wait_ready();
    int unsigned n;
    n = 0;
    while (ready !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (ready !== 1'b1) chk("ready_timeout", {31'd0, ready}, 32'd1);
  endtask

  // One complete operation, with checks on the busy cycle, the completion
  // cycle and the cycle after completion.
  task automatic do_op(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit inj);
    bit exp_err;
    bit eff_inj;
`ifdef REG4_MEM_PARITY_EN
    eff_inj = inj;
`else
    eff_inj = 1'b0;
`endif
    wait_ready();
    sel = 1'b1; wr = w; addr = a; wdata = d; set_inj(inj);
    @(posedge clk); #1;
    // Scramble the request lines; the DUT must use the captured copies.
    sel = 1'b0; wr = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
    set_inj(1'($urandom));
    chk("busy_ready", {31'd0, ready}, 32'd0);
    chk("busy_wdone", {31'd0, wdone}, 32'd0);
    chk("busy_rvalid", {31'd0, rvalid}, 32'd0);
    if (w) begin
      if (int'(a) < int'(DEP)) begin
        m_mem[a] = d;
        m_bad[a] = eff_inj;
      end
      exp_err = (int'(a) >= int'(DEP));
    end else begin
      m_rdata = (int'(a) < int'(DEP)) ? m_mem[a] : '0;
      exp_err = (int'(a) >= int'(DEP)) || m_bad[a];
    end
    @(posedge clk); #1;
    chk(w ? "wr_wdone" : "rd_wdone", {31'd0, wdone}, {31'd0, w});
    chk(w ? "wr_rvalid" : "rd_rvalid", {31'd0, rvalid}, {31'd0, !w});
    chk(w ? "wr_err" : "rd_err", {31'd0, err}, {31'd0, exp_err});
    chk(w ? "wr_rdata_hold" : "rd_rdata", {16'd0, rdata}, {16'd0, m_rdata});
    chk("done_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    chk("pulse_end", {29'd0, wdone, rvalid, err}, 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1; sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0; set_inj(1'b0);
    model_reset();

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_pulses", {29'd0, wdone, rvalid, err}, 32'd0);
    chk("rst_rdata", {16'd0, rdata}, 32'd0);
    for (int i = 0; i < 4; i++) do_op(1'b0, AW'(i), '0, 1'b0);

    // Basic write and read
    do_op(1'b1, 2'd2, 16'hA5C3, 1'b0);
    do_op(1'b0, 2'd2, '0, 1'b0);

    // Back-to-back operations with sel held high; ready alternates.
    wait_ready();
    sel = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 16'h1111;
    @(posedge clk); #1;                        // cycle N+1
    wr = 1'b0;
    chk("b2b_ready1", {31'd0, ready}, 32'd0);
    @(posedge clk); #1;                        // cycle N+2
    chk("b2b_ready2", {31'd0, ready}, 32'd1);
    chk("b2b_wdone", {31'd0, wdone}, 32'd1);
    @(posedge clk); #1;                        // cycle N+3
    sel = 1'b0;
    chk("b2b_ready3", {31'd0, ready}, 32'd0);
    chk("b2b_wdone_low", {31'd0, wdone}, 32'd0);
    @(posedge clk); #1;                        // cycle N+4
    m_mem[0] = 16'h1111;
    m_bad[0] = 1'b0;
    m_rdata  = 16'h1111;
    chk("b2b_ready4", {31'd0, ready}, 32'd1);
    chk("b2b_rvalid", {31'd0, rvalid}, 32'd1);
    chk("b2b_rdata", {16'd0, rdata}, 32'h1111);
    chk("b2b_err", {31'd0, err}, 32'd0);

    // Out-of-range address (DEPTH=3)
    do_op(1'b1, 2'd3, 16'hDEAD, 1'b0);
    do_op(1'b0, 2'd3, '0, 1'b0);
    do_op(1'b0, 2'd2, '0, 1'b0);

    // Reset asserted during the WRITE cycle
    wait_ready();
    sel = 1'b1; wr = 1'b1; addr = 2'd1; wdata = 16'hFFFF;
    @(posedge clk); #1;
    sel = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("midrst_wdone", {31'd0, wdone}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_rdata", {16'd0, rdata}, 32'd0);
    do_op(1'b0, 2'd1, '0, 1'b0);
    do_op(1'b0, 2'd2, '0, 1'b0);

`ifdef REG4_MEM_PARITY_EN
    // Parity injection and recovery
    do_op(1'b1, 2'd1, 16'h0F0F, 1'b1);
    do_op(1'b0, 2'd1, '0, 1'b0);
    do_op(1'b1, 2'd1, 16'h0F0F, 1'b0);
    do_op(1'b0, 2'd1, '0, 1'b0);
`endif

    // Random traffic against the model
    for (int k = 0; k < 40; k++) begin
      do_op(1'($urandom), AW'($urandom_range(3, 0)), DW'($urandom),
            ($urandom_range(3, 0) == 0));
    end
    for (int i = 0; i < 4; i++) do_op(1'b0, AW'(i), '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
